// File: rtl/tc_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tc_timer_pkg
// Purpose : Shared timer/counter constants: bridge address bounds, register
//           offsets, CTRL bit positions, MODE and FSM state encodings.
// Rev     : 1.0  initial release
// ============================================================================
package tc_timer_pkg;

  // Bridge decode windows for the two timer instances
  localparam logic [31:0] C_TC0_BASE = 32'h0000_7F00;
  localparam logic [31:0] C_TC0_LAST = 32'h0000_7F0F;
  localparam logic [31:0] C_TC1_BASE = 32'h0000_7F10;
  localparam logic [31:0] C_TC1_LAST = 32'h0000_7F1F;

  localparam logic [1:0] C_REG_CTRL   = 2'b00;
  localparam logic [1:0] C_REG_PRESET = 2'b01;
  localparam logic [1:0] C_REG_COUNT  = 2'b10;
  localparam logic [1:0] C_REG_RSVD   = 2'b11;

  localparam int C_CTRL_EN      = 0;
  localparam int C_CTRL_MODE_LO = 1;
  localparam int C_CTRL_MODE_HI = 2;
  localparam int C_CTRL_IM      = 3;
  localparam int C_CTRL_W       = 4;

  localparam logic [1:0] C_MODE_ONESHOT = 2'b00;
  localparam logic [1:0] C_MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_CNT  = 2'b10,
    ST_INT  = 2'b11
  } tc_state_t;

endpackage
`default_nettype wire

// File: rtl/tc_timer.sv
`default_nettype none
// ============================================================================
// Module  : tc_timer
// Purpose : Memory-mapped down-counting timer with one-shot / auto-reload
//           modes and a maskable interrupt.
// Rev     : 1.0  initial release
// ============================================================================
module tc_timer
  import tc_timer_pkg::*;
#(
  parameter int W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  tc_state_t           r_state;
  tc_state_t           w_state_nxt;
  logic [C_CTRL_W-1:0] r_ctrl;
  logic [W-1:0]        r_preset;
  logic [W-1:0]        r_count;
  logic                r_flag;

  logic       w_en;
  logic [1:0] w_mode;
  logic       w_wr_ctrl;
  logic       w_wr_preset;
  logic       w_cnt_load;
  logic       w_cnt_dec;
  logic       w_flag_set;
  logic       w_flag_release;
  logic       w_en_clr;
  logic       w_unused_bits;

  assign w_en        = r_ctrl[C_CTRL_EN];
  assign w_mode      = r_ctrl[C_CTRL_MODE_HI:C_CTRL_MODE_LO];
  assign w_wr_ctrl   = we && (addr[3:2] == C_REG_CTRL);
  assign w_wr_preset = we && (addr[3:2] == C_REG_PRESET);

  assign w_unused_bits = ^{addr[31:4], addr[1:0], din[31:C_CTRL_W]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_load     = 1'b0;
    w_cnt_dec      = 1'b0;
    w_flag_set     = 1'b0;
    w_flag_release = 1'b0;
    w_en_clr       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_en) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_cnt_load  = 1'b1;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!w_en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_count != '0) begin
          w_cnt_dec = 1'b1;
        end else begin
          w_flag_set  = 1'b1;
          w_state_nxt = ST_INT;
        end
      end
      ST_INT: begin
        // Reload goes straight back to LOAD so the period is PRESET+3
        if (w_mode == C_MODE_RELOAD) begin
          w_flag_release = 1'b1;
          w_state_nxt    = ST_LOAD;
        end else begin
          w_en_clr    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // A CPU write to CTRL overrides the FSM's one-shot EN clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl <= '0;
    end else if (w_wr_ctrl) begin
      r_ctrl <= din[C_CTRL_W-1:0];
    end else if (w_en_clr) begin
      r_ctrl[C_CTRL_EN] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_preset <= '0;
    end else if (w_wr_preset) begin
      r_preset <= din[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (w_cnt_load) begin
      r_count <= r_preset;
    end else if (w_cnt_dec) begin
      r_count <= r_count - W'(1);
    end
  end

  // Setting wins over a same-edge clear so an expiry is never lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flag <= 1'b0;
    end else if (w_flag_set) begin
      r_flag <= 1'b1;
    end else if (w_wr_ctrl || w_flag_release) begin
      r_flag <= 1'b0;
    end
  end

  assign irq = r_flag & r_ctrl[C_CTRL_IM];

  always_comb begin
    dout = 32'h0;
    case (addr[3:2])
      C_REG_CTRL:   dout = 32'(r_ctrl);
      C_REG_PRESET: dout = 32'(r_preset);
      C_REG_COUNT:  dout = 32'(r_count);
      C_REG_RSVD:   dout = 32'h0;
      default:      dout = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_tc_timer.sv
`default_nettype none
// ============================================================================
// Module  : tb_tc_timer
// Purpose : Directed self-checking bench for tc_timer.
// Rev     : 1.0  initial release
// ============================================================================
module tb_tc_timer;

  localparam logic [31:0] C_A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] C_A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] C_A_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] C_A_RSVD   = 32'h0000_7F0C;

  logic        clk;
  logic        reset_n;
  logic [31:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int n_checks;
  int n_errors;

  tc_timer #(.W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (addr),
    .we      (we),
    .din     (din),
    .dout    (dout),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, dout, exp);
  endtask

  task automatic check_irq(input string tag, input logic exp);
    check(tag, {31'b0, irq}, {31'b0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    we       = 1'b0;
    addr     = 32'h0;
    din      = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_rd("rst_ctrl", C_A_CTRL, 32'h0);
    check_rd("rst_preset", C_A_PRESET, 32'h0);
    check_rd("rst_count", C_A_COUNT, 32'h0);
    check_irq("rst_irq", 1'b0);
    reset_n = 1'b1;
    tick();

    // One-shot, PRESET=5: irq exactly 8 edges after the CTRL write
    wr(C_A_PRESET, 32'd5);
    check_rd("preset_rb", C_A_PRESET, 32'd5);
    wr(C_A_CTRL, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_irq($sformatf("os_irq_e%0d", k), k == 8);
      if (k >= 2 && k <= 7)
        check_rd($sformatf("os_cnt_e%0d", k), C_A_COUNT, 32'(7 - k));
    end
    tick();
    check_rd("os_en_cleared", C_A_CTRL, 32'h8);
    check_irq("os_irq_held", 1'b1);
    repeat (3) tick();
    check_irq("os_irq_still", 1'b1);
    wr(C_A_CTRL, 32'h0);
    check_irq("os_irq_cleared", 1'b0);

    // Auto-reload, PRESET=2: 1-cycle pulse every 5 edges
    wr(C_A_PRESET, 32'd2);
    wr(C_A_CTRL, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_irq($sformatf("ar_irq_e%0d", k), (k % 5) == 0);
    end
    wr(C_A_CTRL, 32'h0);
    tick();

    // IM=0: flag expires silently, then a fresh count with IM=1
    wr(C_A_PRESET, 32'd3);
    wr(C_A_CTRL, 32'h1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_irq($sformatf("m_irq_e%0d", k), 1'b0);
    end
    check_rd("m_en_cleared", C_A_CTRL, 32'h0);
    check_rd("m_count_zero", C_A_COUNT, 32'h0);
    wr(C_A_CTRL, 32'h9);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_irq($sformatf("fr_irq_e%0d", k), k == 6);
      if (k == 2)
        check_rd("fr_count_loaded", C_A_COUNT, 32'd3);
    end
    wr(C_A_CTRL, 32'h0);
    check_irq("fr_irq_cleared", 1'b0);

    // Stop mid-count, COUNT holds; COUNT/reserved writes ignored
    wr(C_A_PRESET, 32'd6);
    wr(C_A_CTRL, 32'h1);
    tick();
    tick();
    check_rd("st_count6", C_A_COUNT, 32'd6);
    wr(C_A_PRESET, 32'd9);
    check_rd("st_preset_no_effect", C_A_COUNT, 32'd5);
    wr(C_A_CTRL, 32'h0);
    check_rd("st_count4", C_A_COUNT, 32'd4);
    repeat (3) tick();
    check_rd("st_count_hold", C_A_COUNT, 32'd4);
    wr(C_A_COUNT, 32'h77);
    check_rd("st_count_ro", C_A_COUNT, 32'd4);
    wr(C_A_RSVD, 32'hFF);
    check_rd("st_rsvd_zero", C_A_RSVD, 32'h0);
    check_rd("st_preset9", C_A_PRESET, 32'd9);
    wr(C_A_CTRL, 32'hFFFF_FFF8);
    check_rd("st_ctrl_upper_zero", C_A_CTRL, 32'h8);
    check_irq("st_irq_zero", 1'b0);
    wr(C_A_CTRL, 32'h0);

    // Asynchronous reset mid-count
    wr(C_A_PRESET, 32'd7);
    wr(C_A_CTRL, 32'h9);
    repeat (4) tick();
    check_rd("ar_pre_count", C_A_COUNT, 32'd5);
    #2;
    reset_n = 1'b0;
    check_rd("ar_ctrl", C_A_CTRL, 32'h0);
    check_rd("ar_preset", C_A_PRESET, 32'h0);
    check_rd("ar_count", C_A_COUNT, 32'h0);
    check_irq("ar_irq", 1'b0);
    #1;
    reset_n = 1'b1;
    repeat (5) tick();
    check_rd("ar_post_ctrl", C_A_CTRL, 32'h0);
    check_rd("ar_post_count", C_A_COUNT, 32'h0);
    check_irq("ar_post_irq", 1'b0);

    // PRESET=0 and a CTRL write in INT winning over the EN clear
    wr(C_A_PRESET, 32'd0);
    wr(C_A_CTRL, 32'h9);
    tick();
    tick();
    check_irq("z_irq_e2", 1'b0);
    tick();
    check_irq("z_irq_e3", 1'b1);
    wr(C_A_CTRL, 32'h9);
    check_rd("pr_ctrl_wins", C_A_CTRL, 32'h9);
    check_irq("pr_irq_cleared", 1'b0);
    tick();
    check_irq("pr_irq_e5", 1'b0);
    tick();
    check_irq("pr_irq_e6", 1'b0);
    tick();
    check_irq("pr_irq_e7", 1'b1);
    wr(C_A_CTRL, 32'h0);
    check_irq("pr_irq_end", 1'b0);
    check_rd("pr_ctrl_end", C_A_CTRL, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
